// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle signed/unsigned restoring divider, quotient+remainder
// Revision : 1.0
// ============================================================================
module seq_divider #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_zero_o
);

   localparam int c_NUM_CYCLES = WIDTH / BITS_PER_CYCLE;
   localparam int c_CNT_W      = $clog2(c_NUM_CYCLES) + 1;
   localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(c_NUM_CYCLES - 1);
   localparam logic [WIDTH-1:0]   c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_FIX  = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [c_CNT_W-1:0] r_cnt;
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic [WIDTH-1:0]   r_quotient;
   logic [WIDTH-1:0]   r_remainder;
   logic               r_div_zero;

   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic               w_div_zero;
   logic               w_ovf;
   logic [WIDTH:0]     w_rem_step;
   logic [WIDTH-1:0]   w_quo_step;
   logic [WIDTH+1:0]   w_trial;
   logic [WIDTH+1:0]   w_diff;

   assign w_a_neg    = signed_i & dividend_i[WIDTH-1];
   assign w_b_neg    = signed_i & divisor_i[WIDTH-1];
   assign w_a_mag    = w_a_neg ? (-dividend_i) : dividend_i;
   assign w_b_mag    = w_b_neg ? (-divisor_i) : divisor_i;
   assign w_div_zero = (divisor_i == '0);
   assign w_ovf      = signed_i && (dividend_i == c_MIN_NEG) && (divisor_i == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE: begin
            if (start_i) begin
               w_state_next = (w_div_zero || w_ovf) ? c_DONE : c_RUN;
            end
         end
         c_RUN: begin
            if (r_cnt == c_LAST) begin
               w_state_next = c_FIX;
            end
         end
         c_FIX:   w_state_next = c_DONE;
         default: w_state_next = c_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (r_state != c_IDLE);
      done_o = (r_state == c_DONE);
   end

   // Chained shift/trial-subtract; the extra top bit of the trial holds the borrow.
   always_comb begin
      w_rem_step = r_rem;
      w_quo_step = r_quo;
      w_trial    = '0;
      w_diff     = '0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         w_trial    = {w_rem_step, w_quo_step[WIDTH-1]};
         w_diff     = w_trial - {2'b00, r_div};
         w_quo_step = {w_quo_step[WIDTH-2:0], ~w_diff[WIDTH+1]};
         w_rem_step = w_diff[WIDTH+1] ? w_trial[WIDTH:0] : w_diff[WIDTH:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_div       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_div_zero  <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start_i) begin
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_rem   <= '0;
                  r_quo   <= w_a_mag;
                  r_div   <= w_b_mag;
                  r_cnt   <= '0;
                  // Early exits land in DONE directly, so results load now.
                  if (w_div_zero) begin
                     r_quotient  <= '1;
                     r_remainder <= dividend_i;
                     r_div_zero  <= 1'b1;
                  end else if (w_ovf) begin
                     r_quotient  <= dividend_i;
                     r_remainder <= '0;
                     r_div_zero  <= 1'b0;
                  end
               end
            end
            c_RUN: begin
               r_rem <= w_rem_step;
               r_quo <= w_quo_step;
               r_cnt <= r_cnt + c_CNT_W'(1);
            end
            c_FIX: begin
               r_quotient  <= r_neg_q ? (-r_quo) : r_quo;
               r_remainder <= (r_neg_r && (r_rem != '0)) ? (-r_rem[WIDTH-1:0])
                                                          : r_rem[WIDTH-1:0];
               r_div_zero  <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign quotient_o  = r_quotient;
   assign remainder_o = r_remainder;
   assign div_zero_o  = r_div_zero;

endmodule
`default_nettype wire
